uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, stop-bit periods per frame; legal values 1 and 2.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port txclk_en  input  1  one-cycle bit-period strobe from the baud generator.
REQ-005 SHALL have port req0_valid  input  1  requester 0 offers a byte.
REQ-006 SHALL have port req0_data  input  8  requester 0 byte.
REQ-007 SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_data, req1_ready, identical to REQ-005..007 for requester 1.
REQ-009 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-010 SHALL have port busy  output  1  high from accept until frame end.
REQ-011 SHALL have port grant_id  output  1  index of most recently accepted requester, registered.

Function
REQ-012 SHALL implement FSM states IDLE, SYNC, START, DATA, STOP.
REQ-013 SHALL, in IDLE only, assert exactly one reqN_ready, combinationally, for the selected requester; ready SHALL be 0 in all other states.
REQ-014 SHALL select: only one valid -> that one; both valid -> the one not equal to grant_id (round-robin); none -> no ready.
REQ-015 SHALL, on valid&ready, latch data into the shift register, update grant_id, set busy, and go to SYNC.
REQ-016 SHALL ignore txclk_en in the accept cycle; SYNC waits for the next txclk_en, then goes to START and drives tx=0 from the following cycle.
REQ-017 SHALL hold each bit for exactly one txclk_en period, advancing state/bit only on cycles with txclk_en=1.
REQ-018 SHALL send 8 data bits LSB first in DATA, using a 3-bit counter that wraps 7->0 on leaving DATA.
REQ-019 SHALL drive tx=1 in STOP for STOP_BITS periods; on the txclk_en ending the last stop period, go to IDLE and clear busy.
REQ-020 SHALL drive tx=1 in IDLE and SYNC.
REQ-021 SHALL, when requests are back-to-back, yield frame spacing of exactly 10+STOP_BITS txclk_en periods start-to-start (one idle period from SYNC).
REQ-022 SHALL treat txclk_en held high continuously as one bit per clock, without skipping states.
REQ-023 SHALL ignore valid drops, or data changes, after acceptance; the latched byte is sent unchanged.
REQ-024 SHALL not accept during busy; requesters hold valid until ready.

Reset
REQ-025 SHALL, on rst assertion, immediately (asynchronously) set state=IDLE, tx=1, busy=0, grant_id=1, shift register=0, bit counter=0.
REQ-026 SHALL abandon a frame in progress on mid-frame reset, with no resumption after release.
REQ-027 SHALL make requester 0 win the first simultaneous request after reset (grant_id reset value 1).
REQ-028 SHALL drive req0_ready=req1_ready=0 while rst is high.

Verification
REQ-029 SHALL cover: req0 sends 0xA5, STOP_BITS=1, txclk_en every 4 cycles -> tx=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy falls at the final strobe; grant_id=0.
REQ-030 SHALL cover: both valid from reset with 0x11 and 0x22, held -> frames 0x11 then 0x22, grant_id 0 then 1, start bits 11 periods apart.
REQ-031 SHALL cover: txclk_en asserted in the accept cycle -> no start bit at that strobe; start begins after the next strobe.
REQ-032 SHALL cover: rst asserted during DATA bit 3 -> tx=1 and busy=0 asynchronously, not on the next edge; after release, IDLE with req0 priority.
REQ-033 SHALL cover: STOP_BITS=2, txclk_en constant 1, byte 0x00 -> tx low for 9 cycles, high for 2, busy high for 12 cycles including SYNC.
REQ-034 SHALL cover: req1 only, valid dropped one cycle after ready -> full frame of the latched byte still sent; no second accept.

Source files
------------

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : 8N1/8N2 UART transmitter fed by two byte requesters.
//                A round-robin arbiter hands out a combinational ready in
//                IDLE. The accepted byte is latched and serialised
//                LSB-first, one bit per txclk_en strobe:
//                start, 8 data bits, then STOP_BITS stop periods.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arb #(
  parameter int STOP_BITS = 1            // stop-bit periods per frame: 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txclk_en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_SYNC  = 3'd1;
  localparam logic [2:0] c_ST_START = 3'd2;
  localparam logic [2:0] c_ST_DATA  = 3'd3;
  localparam logic [2:0] c_ST_STOP  = 3'd4;

  // Index of the final data bit and of the final stop period.
  localparam logic [2:0] c_LAST_BIT  = 3'd7;
  localparam logic       c_STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0] r_state;
  logic [2:0] w_state_nxt;

  logic       r_tx;
  logic       r_busy;
  logic       r_grant_id;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_stop_cnt;

  logic       w_sel0;
  logic       w_sel1;
  logic       w_accept;
  logic       w_bit_last;
  logic       w_stop_last;

  assign w_accept    = w_sel0 | w_sel1;
  assign w_bit_last  = (r_bit_cnt == c_LAST_BIT);
  assign w_stop_last = (r_stop_cnt == c_STOP_LAST);

  // --------------------------------------------------------------------------
  // Arbiter: only in IDLE and never while reset is applied. With both
  // requesters valid the one that did not win last time is chosen; grant_id
  // resets to 1 so requester 0 wins the first tie.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel0 = 1'b0;
    w_sel1 = 1'b0;
    if ((r_state == c_ST_IDLE) && !rst) begin
      if (req0_valid && req1_valid) begin
        w_sel0 = r_grant_id;
        w_sel1 = ~r_grant_id;
      end else begin
        w_sel0 = req0_valid;
        w_sel1 = req1_valid;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic. The accept cycle ignores txclk_en; SYNC lines the
  // frame up with the next strobe so the start bit lasts a full period.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_ST_SYNC;
        end
      end
      c_ST_SYNC: begin
        if (txclk_en) begin
          w_state_nxt = c_ST_START;
        end
      end
      c_ST_START: begin
        if (txclk_en) begin
          w_state_nxt = c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (txclk_en && w_bit_last) begin
          w_state_nxt = c_ST_STOP;
        end
      end
      c_ST_STOP: begin
        if (txclk_en && w_stop_last) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs: ready handshakes and registered line/status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req0_ready = w_sel0;
    req1_ready = w_sel1;
    tx         = r_tx;
    busy       = r_busy;
    grant_id   = r_grant_id;
  end

  // --------------------------------------------------------------------------
  // Datapath: byte latch, serialiser and counters. tx is loaded on the same
  // edge that enters a state with the value that state drives, so the line
  // changes only on strobe edges (and on accept, where it stays high).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_grant_id <= 1'b1;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_shift    <= w_sel1 ? req1_data : req0_data;
            r_grant_id <= w_sel1;
            r_busy     <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
          end
        end
        c_ST_SYNC: begin
          if (txclk_en) begin
            r_tx <= 1'b0;
          end
        end
        c_ST_START: begin
          if (txclk_en) begin
            r_tx      <= r_shift[0];
            r_bit_cnt <= 3'd0;
          end
        end
        c_ST_DATA: begin
          if (txclk_en) begin
            if (w_bit_last) begin
              // Counter wraps to 0 as the frame moves into its stop period.
              r_tx       <= 1'b1;
              r_bit_cnt  <= 3'd0;
              r_stop_cnt <= 1'b0;
            end else begin
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        c_ST_STOP: begin
          r_tx <= 1'b1;
          if (txclk_en) begin
            if (w_stop_last) begin
              r_busy     <= 1'b0;
              r_stop_cnt <= 1'b0;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arb
//  Description : Directed self-checking bench for uart_tx_arb. dut1 uses
//                STOP_BITS=1 with a strobe every 4 cycles; dut2 uses
//                STOP_BITS=2 with the strobe held high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arb;

  logic       clk;
  logic       rst;

  logic       txen1;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       r0, r1, tx1, busy1, grant1;

  logic       txen2;
  logic       v20, v21;
  logic [7:0] d20, d21;
  logic       r20, r21, tx2, busy2, grant2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit         req;
    logic [7:0] data;
    logic [0:9] bits;     // start, d0..d7, stop in line order
    bit         grant;
    bit         align;    // present the byte on a strobe cycle
  } frame_t;

  typedef struct {
    logic       va;
    logic       vb;
    logic [1:0] exp;      // {req0_ready, req1_ready}
  } arb_t;

  uart_tx_arb #(.STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .txclk_en(txen1),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .tx(tx1), .busy(busy1), .grant_id(grant1)
  );

  uart_tx_arb #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .txclk_en(txen2),
    .req0_valid(v20), .req0_data(d20), .req0_ready(r20),
    .req1_valid(v21), .req1_data(d21), .req1_ready(r21),
    .tx(tx2), .busy(busy2), .grant_id(grant2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe for dut1: one cycle in four, changed on the falling edge.
  initial begin
    txen1 = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      txen1 = ((cyc % 4) == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte to dut1, follow the frame to the end and check the line
  // value at every strobe, that tx only moves after a strobe, and that busy
  // drops on the strobe ending the stop bit. Entered and left at negedge+1.
  task automatic run_frame(input bit req, input logic [7:0] data, input logic [0:9] bits,
                           input bit exp_grant, input bit align, output int start_cyc);
    logic [0:10] expv;
    logic [0:10] samp;
    int          n;
    int          k;
    bit          got;
    logic        prev_tx;
    logic        prev_en;
    expv      = {1'b1, bits};
    samp      = '1;
    start_cyc = -1;
    if (align) begin
      k = 0;
      while (!txen1 && k < 20) begin
        @(negedge clk); #1; k++;
      end
    end
    if (req) begin v1 = 1'b1; d1 = data; end
    else     begin v0 = 1'b1; d0 = data; end
    #1;
    got = 1'b0;
    for (int w = 0; w < 300; w++) begin
      if ((req ? r1 : r0) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("ready_seen", got, 1'b1);
    if (align) chk("accept_on_strobe", txen1, 1'b1);
    @(posedge clk);
    @(negedge clk); #1;
    chk("busy_after_accept", busy1, 1'b1);
    chk("grant_id", grant1, exp_grant);
    // Requester lets go and scribbles on its data; the latched byte must win.
    if (req) begin v1 = 1'b0; d1 = ~data; end
    else     begin v0 = 1'b0; d0 = ~data; end
    n       = 0;
    prev_tx = tx1;
    prev_en = 1'b0;
    for (k = 0; k < 300; k++) begin
      if (busy1 !== 1'b1) break;
      if (tx1 === 1'b0 && start_cyc < 0) start_cyc = cyc;
      if (txen1) begin
        if (n < 11) samp[n] = tx1;
        n++;
      end
      prev_en = txen1;
      prev_tx = tx1;
      @(negedge clk); #1;
      if (tx1 !== prev_tx) chk("tx_changes_only_after_strobe", prev_en, 1'b1);
    end
    chk("frame_finished", (k < 300), 1'b1);
    chk("strobes_in_frame", n, 11);
    for (int i = 0; i < 11; i++) chk($sformatf("bit%0d_of_%0h", i, data), samp[i], expv[i]);
    chk("busy_falls_at_strobe", prev_en, 1'b1);
    chk("tx_idle_after_frame", tx1, 1'b1);
  endtask

  frame_t frames[3];
  arb_t   arbv[4];
  int     s0, s1, k, n, bad;
  int     busy_cnt, low_cnt, high_cnt;

  initial begin
    arbv[0] = '{1'b0, 1'b0, 2'b00};
    arbv[1] = '{1'b1, 1'b0, 2'b10};
    arbv[2] = '{1'b0, 1'b1, 2'b01};
    arbv[3] = '{1'b1, 1'b1, 2'b10};   // tie after reset: requester 0

    frames[0] = '{1'b1, 8'h5A, 10'b0_01011010_1, 1'b1, 1'b1};
    frames[1] = '{1'b1, 8'h3C, 10'b0_00111100_1, 1'b1, 1'b0};
    frames[2] = '{1'b0, 8'hA5, 10'b0_10100101_1, 1'b0, 1'b0};

    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h00; d1 = 8'h00;
    v20 = 1'b0; v21 = 1'b0; d20 = 8'h00; d21 = 8'h00; txen2 = 1'b1;

    // Reset applied between clock edges; outputs must follow at once.
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", tx1, 1'b1);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_grant", grant1, 1'b1);
    chk("rst_ready", {r0, r1}, 2'b00);
    chk("rst_tx2", tx2, 1'b1);
    chk("rst_busy2", busy2, 1'b0);
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    // Arbitration table, valids withdrawn before each clock edge.
    for (int i = 0; i < 4; i++) begin
      v0 = arbv[i].va; v1 = arbv[i].vb;
      #1;
      chk($sformatf("arb_vec%0d", i), {r0, r1}, arbv[i].exp);
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk); #1;
    end

    // Both requesters from reset, held: 0x11 first, then 0x22, 11 periods apart.
    v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22;
    run_frame(1'b0, 8'h11, 10'b0_10001000_1, 1'b0, 1'b0, s0);
    run_frame(1'b1, 8'h22, 10'b0_01000100_1, 1'b1, 1'b0, s1);
    chk("start_to_start_cycles", s1 - s0, 44);

    // Single-requester frames; after each, no further accept may happen.
    for (int i = 0; i < 3; i++) begin
      run_frame(frames[i].req, frames[i].data, frames[i].bits, frames[i].grant,
                frames[i].align, s0);
      bad = 0;
      repeat (12) begin
        if (busy1 !== 1'b0) bad++;
        @(negedge clk); #1;
      end
      chk($sformatf("no_reaccept_%0d", i), bad, 0);
    end

    // grant_id is now 0, so a tie goes to requester 1.
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("arb_tie_after_req0", {r0, r1}, 2'b01);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk); #1;

    // Reset during data bit 3 of 0xF7 (bit 3 is the only zero data bit).
    v0 = 1'b1; d0 = 8'hF7;
    #1;
    k = 0;
    while (r0 !== 1'b1 && k < 100) begin @(negedge clk); #1; k++; end
    @(posedge clk);
    @(negedge clk); #1;
    v0 = 1'b0;
    k = 0;
    while (tx1 !== 1'b0 && k < 100) begin @(negedge clk); #1; k++; end
    n = 0; k = 0;
    while (n < 4 && k < 100) begin
      if (txen1) n++;
      @(negedge clk); #1; k++;
    end
    chk("bit3_tx_low", tx1, 1'b0);
    chk("bit3_busy", busy1, 1'b1);
    v0 = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_tx_async", tx1, 1'b1);
    chk("midrst_busy_async", busy1, 1'b0);
    chk("midrst_ready", r0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0; v0 = 1'b0;
    #1;
    bad = 0;
    repeat (30) begin
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
      @(negedge clk); #1;
    end
    chk("no_resume_after_rst", bad, 0);
    chk("grant_after_rst", grant1, 1'b1);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("arb_req0_after_rst", {r0, r1}, 2'b10);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk); #1;

    // dut2: two stop bits, strobe always high, byte 0x00.
    v20 = 1'b1; d20 = 8'h00;
    #1;
    chk("dut2_ready", r20, 1'b1);
    @(posedge clk);
    @(negedge clk); #1;
    v20 = 1'b0;
    busy_cnt = 0; low_cnt = 0; high_cnt = 0;
    for (int w = 0; w < 50; w++) begin
      if (busy2 !== 1'b1) break;
      busy_cnt++;
      if (tx2 === 1'b0) low_cnt++;
      else if (low_cnt > 0) high_cnt++;
      @(negedge clk); #1;
    end
    chk("dut2_busy_cycles", busy_cnt, 12);
    chk("dut2_low_cycles", low_cnt, 9);
    chk("dut2_stop_cycles", high_cnt, 2);
    chk("dut2_grant", grant2, 1'b0);
    chk("dut2_idle_tx", tx2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
